// File: rtl/tdm_pkg.sv
// Shared types, constants and beat-capture helper for the 4-slot TDM receive path.
package tdm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  localparam int SLOTS           = 4;
  localparam int SLOT_W          = 2;
  localparam int TIMEOUT_DEFAULT = 15;

  // A high (inactive) section strobe forces that section's bit to 0, as the mux would.
  function automatic logic [1:0] tdm_cap(input logic [1:0] y, input logic [1:0] s);
    return y & ~s;
  endfunction

endpackage

// File: rtl/tdm_timeout_cnt.sv
// Idle-cycle counter: clears on demand, counts while inc is high, flags the cycle it would reach TIMEOUT.
module tdm_timeout_cnt #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] count_reg;

  // Expiry is combinational so the owner can react on the same edge the count would hit TIMEOUT.
  assign expire = inc & ~clr & (count_reg == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clr || expire) begin
      count_reg <= '0;
    end else if (inc) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/tdm_demux4.sv
// Receive side of a 4-slot TDM link: steers 2-bit beats into shadow bits and commits {d1, d2} per frame.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_sync,
  input  logic [1:0]        in_y,
  input  logic [1:0]        in_s,
  output logic [SLOTS-1:0]  d1,
  output logic [SLOTS-1:0]  d2,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic [SLOT_W-1:0] slot
);

  state_t            state_reg, state_next;
  logic [SLOT_W-1:0] slot_reg;
  logic [SLOTS-1:0]  d1_reg, d2_reg;
  logic              done_reg, err_reg;

  // Only slots 0..2 need shadow storage; slot 3 is taken straight from the beat at commit.
  logic [SLOTS-2:0]  sh1, sh2;

  logic [1:0]        cap;
  logic              start_frame, capture, commit, abort_sync, timeout;
  logic              tmr_inc, tmr_clr, tmr_expire;

  assign cap = tdm_cap(in_y, in_s);

  assign tmr_inc = (state_reg == RECV) && !in_valid;
  assign tmr_clr = !tmr_inc;
  assign timeout = tmr_expire;

  tdm_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (tmr_clr),
    .inc    (tmr_inc),
    .expire (tmr_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid && in_sync) state_next = RECV;
      RECV:    if (commit || timeout)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    start_frame = 1'b0;
    capture     = 1'b0;
    commit      = 1'b0;
    abort_sync  = 1'b0;
    case (state_reg)
      IDLE: start_frame = in_valid && in_sync;
      RECV: begin
        if (in_valid) begin
          if (in_sync) begin
            start_frame = 1'b1;
            abort_sync  = 1'b1;
          end else if (slot_reg == SLOT_W'(SLOTS - 1)) begin
            commit = 1'b1;
          end else begin
            capture = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_reg <= '0;
      d1_reg   <= '0;
      d2_reg   <= '0;
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
    end else begin
      done_reg <= commit;
      err_reg  <= abort_sync || timeout;
      if (start_frame) begin
        slot_reg <= SLOT_W'(1);
      end else if (capture) begin
        slot_reg <= slot_reg + 1'b1;
      end else if (commit || timeout) begin
        slot_reg <= '0;
      end
      if (commit) begin
        d1_reg <= {cap[0], sh1};
        d2_reg <= {cap[1], sh2};
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < SLOTS - 1; gi++) begin : g_slot
      logic [1:0] pair_reg;

      // A new sync wipes any partial frame so stale bits can never leak into a commit.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pair_reg <= 2'b00;
        end else if (timeout) begin
          pair_reg <= 2'b00;
        end else if (start_frame) begin
          pair_reg <= (gi == 0) ? cap : 2'b00;
        end else if (capture && (slot_reg == SLOT_W'(gi))) begin
          pair_reg <= cap;
        end
      end

      assign sh1[gi] = pair_reg[0];
      assign sh2[gi] = pair_reg[1];
    end
  endgenerate

  assign d1   = d1_reg;
  assign d2   = d2_reg;
  assign done = done_reg;
  assign err  = err_reg;
  assign busy = (state_reg == RECV);
  assign slot = slot_reg;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4: frames, strobes, gaps, early sync, timeout and async reset.
module tb_tdm_demux4;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_sync;
  logic [1:0] in_y;
  logic [1:0] in_s;
  logic [3:0] d1;
  logic [3:0] d2;
  logic       done;
  logic       err;
  logic       busy;
  logic [1:0] slot;

  int n_tests = 0;
  int n_fail  = 0;

  tdm_demux4 #(.TIMEOUT(15)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_sync  (in_sync),
    .in_y     (in_y),
    .in_s     (in_s),
    .d1       (d1),
    .d2       (d2),
    .done     (done),
    .err      (err),
    .busy     (busy),
    .slot     (slot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of input at a falling edge; returns at the next falling edge.
  task automatic step(input logic v, input logic sy, input logic [1:0] y, input logic [1:0] s);
    in_valid = v;
    in_sync  = sy;
    in_y     = y;
    in_s     = s;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 2'd0, 2'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sync = 1'b0; in_y = 2'd0; in_s = 2'd0;
    repeat (2) @(negedge clk);
    chk("rst_d1", d1, 0);   chk("rst_d2", d2, 0);   chk("rst_done", done, 0);
    chk("rst_err", err, 0); chk("rst_busy", busy, 0); chk("rst_slot", slot, 0);
    rst_n = 1'b1;

    // Non-sync beat in IDLE is ignored
    step(1, 0, 2'd3, 2'd0);
    chk("idle_ign_busy", busy, 0); chk("idle_ign_slot", slot, 0);

    // Basic frame d1=1010 d2=0110
    step(1, 1, 2'd0, 2'd0);
    chk("basic_busy", busy, 1); chk("basic_slot1", slot, 1);
    step(1, 0, 2'd3, 2'd0);
    step(1, 0, 2'd2, 2'd0);
    chk("basic_slot3", slot, 3); chk("basic_nodone", done, 0);
    step(1, 0, 2'd1, 2'd0);
    $display("[TB] basic frame: d1=%b d2=%b done=%b", d1, d2, done);
    chk("basic_done", done, 1); chk("basic_d1", d1, 4'hA); chk("basic_d2", d2, 4'h6);
    chk("basic_busy_drop", busy, 0); chk("basic_slot0", slot, 0);
    idle(1);
    chk("basic_done_pulse", done, 0);

    // Strobe masking, section 1 disabled
    step(1, 1, 2'd0, 2'b01); step(1, 0, 2'd3, 2'b01);
    step(1, 0, 2'd2, 2'b01); step(1, 0, 2'd1, 2'b01);
    $display("[TB] strobe frame: d1=%b d2=%b done=%b", d1, d2, done);
    chk("strobe_done", done, 1); chk("strobe_d1", d1, 4'h0); chk("strobe_d2", d2, 4'h6);

    // Frame A5 with gaps: d1=1010 d2=0101
    step(1, 1, 2'd2, 2'd0); idle(3);
    step(1, 0, 2'd1, 2'd0); idle(1);
    step(1, 0, 2'd2, 2'd0); idle(2);
    chk("gapA_err", err, 0); chk("gapA_busy", busy, 1);
    step(1, 0, 2'd1, 2'd0);
    $display("[TB] frame A5: d1=%b d2=%b done=%b", d1, d2, done);
    chk("gapA_done", done, 1); chk("gapA_d1", d1, 4'hA); chk("gapA_d2", d2, 4'h5);

    // Frame 3C immediately after: d1=0011 d2=1100
    step(1, 1, 2'd1, 2'd0);
    chk("b2b_done_low", done, 0); chk("b2b_busy", busy, 1);
    idle(2);
    step(1, 0, 2'd1, 2'd0);
    step(1, 0, 2'd2, 2'd0); idle(3);
    step(1, 0, 2'd2, 2'd0);
    $display("[TB] frame 3C: d1=%b d2=%b done=%b", d1, d2, done);
    chk("gapB_done", done, 1); chk("gapB_d1", d1, 4'h3); chk("gapB_d2", d2, 4'hC);

    // Early sync restarts the frame: new frame d1=0101 d2=1001
    step(1, 1, 2'd3, 2'd0);
    step(1, 0, 2'd3, 2'd0);
    step(1, 1, 2'd3, 2'd0);
    $display("[TB] early sync: err=%b slot=%0d", err, slot);
    chk("esync_err", err, 1); chk("esync_slot", slot, 1); chk("esync_busy", busy, 1);
    chk("esync_nodone", done, 0); chk("esync_d1_hold", d1, 4'h3); chk("esync_d2_hold", d2, 4'hC);
    step(1, 0, 2'd0, 2'd0);
    chk("esync_err_pulse", err, 0);
    step(1, 0, 2'd1, 2'd0);
    step(1, 0, 2'd2, 2'd0);
    $display("[TB] early sync frame: d1=%b d2=%b done=%b", d1, d2, done);
    chk("esync_done", done, 1); chk("esync_d1", d1, 4'h5); chk("esync_d2", d2, 4'h9);

    // Timeout after 2 beats and 15 idle cycles
    step(1, 1, 2'd0, 2'd0); step(1, 0, 2'd3, 2'd0);
    idle(14);
    chk("tmo_err_early", err, 0); chk("tmo_busy_early", busy, 1);
    idle(1);
    $display("[TB] timeout: err=%b busy=%b slot=%0d", err, busy, slot);
    chk("tmo_err", err, 1); chk("tmo_slot", slot, 0); chk("tmo_busy", busy, 0);
    chk("tmo_nodone", done, 0); chk("tmo_d1", d1, 4'h5); chk("tmo_d2", d2, 4'h9);
    idle(1);
    chk("tmo_err_pulse", err, 0);

    // Beat on the expiry cycle wins; frame d1=0110 d2=1010
    step(1, 1, 2'd0, 2'd0); step(1, 0, 2'd3, 2'd0);
    idle(14);
    step(1, 0, 2'd1, 2'd0);
    $display("[TB] valid wins: err=%b busy=%b slot=%0d", err, busy, slot);
    chk("vwin_err", err, 0); chk("vwin_busy", busy, 1); chk("vwin_slot", slot, 3);
    idle(14);
    chk("vwin_busy2", busy, 1); chk("vwin_err2", err, 0);
    step(1, 0, 2'd2, 2'd0);
    chk("vwin_done", done, 1); chk("vwin_d1", d1, 4'h6); chk("vwin_d2", d2, 4'hA);

    // Asynchronous reset mid-frame
    step(1, 1, 2'd3, 2'd0); step(1, 0, 2'd3, 2'd0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    $display("[TB] async reset: d1=%b d2=%b busy=%b slot=%0d", d1, d2, busy, slot);
    chk("arst_d1", d1, 0); chk("arst_d2", d2, 0); chk("arst_busy", busy, 0);
    chk("arst_slot", slot, 0); chk("arst_done", done, 0); chk("arst_err", err, 0);
    @(negedge clk);
    chk("arst_err_hold", err, 0);
    rst_n = 1'b1;
    step(1, 1, 2'd0, 2'd0); step(1, 0, 2'd3, 2'd0);
    step(1, 0, 2'd2, 2'd0); step(1, 0, 2'd1, 2'd0);
    $display("[TB] post-reset frame: d1=%b d2=%b done=%b", d1, d2, done);
    chk("post_done", done, 1); chk("post_d1", d1, 4'hA); chk("post_d2", d2, 4'h6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
